// File: rtl/topaz_geyser_pkg.sv
// Shared types for the topaz_geyser external SRAM controller.
// Also holds the byte-selection helper used to walk the byte lanes of a word.
package topaz_geyser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } mem_port_t;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned LANES   = 4;

    // Lowest enabled byte lane of a mask; 0 when the mask is empty.
    function automatic logic [1:0] lowest_byte(input logic [3:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        if (mask[0])      idx = 2'd0;
        else if (mask[1]) idx = 2'd1;
        else if (mask[2]) idx = 2'd2;
        else if (mask[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/ext_mem_controller.sv
// Two-port arbiter/sequencer for a byte-wide external SRAM: splits 32-bit word
// requests from the fetch and data ports into byte cycles on an 8-bit bus.
module ext_mem_controller
    import topaz_geyser_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              sys_clk,
    input  logic              cpu_rst,

    input  logic              if_req,
    input  logic [ADDR_W-3:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-3:0] d_addr,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,

    output logic              busy,
    output logic [1:0]        o_dbg_state,

    output logic              ic_we,
    inout  wire  [7:0]        ic_io,
    output logic [ADDR_W-1:0] ic_addr
);

    localparam int WAW = ADDR_W - 2;
    localparam int WCW = $clog2(WAIT_CYCLES + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES - 1);

    mem_state_t        r_state;
    mem_state_t        w_state_next;
    mem_port_t         r_port;
    mem_port_t         r_rr_last;
    mem_port_t         w_grant_port;

    logic              r_we;
    logic [WAW-1:0]    r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_mask;
    logic [1:0]        r_idx;
    logic [WCW-1:0]    r_wait;
    logic [ADDR_W-1:0] r_ic_addr;
    logic [31:0]       r_buf;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_d_rdata;

    logic              w_grant;
    logic              w_grant_we;
    logic [WAW-1:0]    w_grant_addr;
    logic [3:0]        w_grant_mask;
    logic [3:0]        w_rem_mask;
    logic              w_last_wait;
    logic              w_capture;
    logic [31:0]       w_buf_next;
    logic              w_drive_en;
    logic [7:0]        w_drive_byte;

    always_ff @(posedge sys_clk) begin
        if (cpu_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_port = PORT_FETCH;
        w_grant_we   = 1'b0;
        w_grant_addr = if_addr;
        w_grant_mask = 4'hf;
        w_last_wait  = (r_wait == WAIT_LAST);
        w_rem_mask   = r_mask & ~(4'b0001 << r_idx);
        w_capture    = 1'b0;

        // A tie goes to whichever port was not served last.
        if (if_req && d_req) begin
            w_grant_port = (r_rr_last == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
        end else if (d_req) begin
            w_grant_port = PORT_DATA;
        end

        if (w_grant_port == PORT_DATA) begin
            w_grant_we   = d_we;
            w_grant_addr = d_addr;
            w_grant_mask = d_we ? d_be : 4'hf;
        end

        case (r_state)
            IDLE: begin
                if (if_req || d_req) begin
                    w_grant      = 1'b1;
                    w_state_next = (w_grant_mask == 4'h0) ? DONE : SETUP;
                end
            end
            SETUP: begin
                w_state_next = ACCESS;
            end
            ACCESS: begin
                if (w_last_wait) begin
                    w_capture    = !r_we;
                    w_state_next = (w_rem_mask != 4'h0) ? SETUP : DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        w_buf_next = r_buf;
        if (w_capture) begin
            w_buf_next[{r_idx, 3'b000} +: 8] = ic_io;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (cpu_rst) begin
            r_port     <= PORT_FETCH;
            r_rr_last  <= PORT_FETCH;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mask     <= '0;
            r_idx      <= '0;
            r_wait     <= '0;
            r_ic_addr  <= '0;
            r_buf      <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_buf <= w_buf_next;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_port    <= w_grant_port;
                        r_rr_last <= w_grant_port;
                        r_we      <= w_grant_we;
                        r_addr    <= w_grant_addr;
                        r_wdata   <= d_wdata;
                        r_mask    <= w_grant_mask;
                        r_idx     <= lowest_byte(w_grant_mask);
                        // An empty store mask leaves the bus completely untouched.
                        if (w_grant_mask != 4'h0) begin
                            r_ic_addr <= {w_grant_addr, lowest_byte(w_grant_mask)};
                        end
                    end
                end
                SETUP: begin
                    r_wait <= '0;
                end
                ACCESS: begin
                    if (!w_last_wait) begin
                        r_wait <= r_wait + WCW'(1);
                    end else begin
                        r_mask <= w_rem_mask;
                        if (w_rem_mask != 4'h0) begin
                            r_idx     <= lowest_byte(w_rem_mask);
                            r_ic_addr <= {r_addr, lowest_byte(w_rem_mask)};
                        end else if (!r_we) begin
                            if (r_port == PORT_FETCH) begin
                                r_if_rdata <= w_buf_next;
                            end else begin
                                r_d_rdata <= w_buf_next;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Store data is on the bus from SETUP onward so it is stable before ic_we rises.
    assign w_drive_en   = r_we && ((r_state == SETUP) || (r_state == ACCESS));
    assign w_drive_byte = r_wdata[{r_idx, 3'b000} +: 8];
    assign ic_io        = w_drive_en ? w_drive_byte : 8'bz;

    assign ic_we        = (r_state == ACCESS) && r_we;
    assign ic_addr      = r_ic_addr;
    assign if_ack       = (r_state == DONE) && (r_port == PORT_FETCH);
    assign d_ack        = (r_state == DONE) && (r_port == PORT_DATA);
    assign if_rdata     = r_if_rdata;
    assign d_rdata      = r_d_rdata;
    assign busy         = (r_state != IDLE);
    assign o_dbg_state  = r_state;

endmodule
